// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide execute unit, one step per clock.
// Ports: clk, rst (sync, active-high); start/op/op_a/op_b/rd_addr request;
//        busy/done handshake; wr_en/wr_addr/wr_data register-file write-back.
module muldiv_unit #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              busy,
   output logic              done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [2:0]          op_q;
   logic [ADDR_W-1:0]   rd_q;
   logic                neg_q;
   logic                divz_q;
   // hi: partial product high half / partial remainder (one guard bit)
   // lo: multiplier bits / dividend bits shifting into quotient
   logic [WIDTH:0]      hi;
   logic [WIDTH-1:0]    lo;
   logic [WIDTH-1:0]    dvs;

   // request decode
   logic                a_sgn;
   logic                b_sgn;
   logic                sa;
   logic                sb;
   logic [WIDTH-1:0]    mag_a;
   logic [WIDTH-1:0]    mag_b;
   logic                neg_d;

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      unique case (op)
         3'b001, 3'b100, 3'b110: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         3'b010:  a_sgn = 1'b1;
         default: ;
      endcase
      sa    = a_sgn & op_a[WIDTH-1];
      sb    = b_sgn & op_b[WIDTH-1];
      mag_a = sa ? (~op_a + 1'b1) : op_a;
      mag_b = sb ? (~op_b + 1'b1) : op_b;
      // remainder follows the dividend; everything else follows a^b
      neg_d = (op[2] & op[1]) ? sa : (sa ^ sb);
   end

   // one iteration step
   logic [WIDTH:0]      mul_sum;
   logic [WIDTH:0]      r_sh;
   logic [WIDTH:0]      trial;
   logic [WIDTH:0]      step_hi;
   logic [WIDTH-1:0]    step_lo;

   always_comb begin
      mul_sum = {1'b0, hi[WIDTH-1:0]}
              + (lo[0] ? {1'b0, dvs} : '0);
      r_sh    = {hi[WIDTH-1:0], lo[WIDTH-1]};
      trial   = r_sh - {1'b0, dvs};
      if (op_q[2]) begin
         // restoring divide: keep the trial only if it stayed non-negative
         if (!trial[WIDTH]) begin
            step_hi = trial;
            step_lo = {lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = r_sh;
            step_lo = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi = {1'b0, mul_sum[WIDTH:1]};
         step_lo = {mul_sum[0], lo[WIDTH-1:1]};
      end
   end

   // final sign correction and result selection
   logic [2*WIDTH-1:0]  prod;
   logic [2*WIDTH-1:0]  prod_s;
   logic [WIDTH-1:0]    quot_s;
   logic [WIDTH-1:0]    rem_s;
   logic [WIDTH-1:0]    result;

   always_comb begin
      prod   = {step_hi[WIDTH-1:0], step_lo};
      prod_s = neg_q ? (~prod + 1'b1) : prod;
      quot_s = neg_q ? (~step_lo + 1'b1) : step_lo;
      rem_s  = neg_q ? (~step_hi[WIDTH-1:0] + 1'b1)
                     : step_hi[WIDTH-1:0];
      result = '0;
      unique case (op_q)
         3'b000:                 result = prod_s[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: result = prod_s[2*WIDTH-1:WIDTH];
         // divide by zero: the remainder path already yields op_a,
         // only the quotient needs substituting
         3'b100, 3'b101:         result = divz_q ? '1 : quot_s;
         default:                result = rem_s;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         neg_q   <= 1'b0;
         divz_q  <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         dvs     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_q   <= op;
                  rd_q   <= rd_addr;
                  neg_q  <= neg_d;
                  divz_q <= (op_b == '0);
                  hi     <= '0;
                  lo     <= mag_a;
                  dvs    <= mag_b;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               hi  <= step_hi;
               lo  <= step_lo;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  wr_data <= result;
                  wr_addr <= rd_q;
                  wr_en   <= (rd_q != '0);
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               wr_en   <= 1'b0;
               wr_addr <= '0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against an arithmetic model.
// Stimulus pushes expectations; a negedge monitor pops on every done pulse.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic [2:0]  rd_addr = '0;
   logic        busy;
   logic        done;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;

   muldiv_unit #(.WIDTH(16), .ADDR_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .op_a    (op_a),
      .op_b    (op_b),
      .rd_addr (rd_addr),
      .busy    (busy),
      .done    (done),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  addr;
      logic        we;
      int          at;
      string       name;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic string opname(input logic [2:0] f);
      case (f)
         3'd0: return "MUL";
         3'd1: return "MULH";
         3'd2: return "MULHSU";
         3'd3: return "MULHU";
         3'd4: return "DIV";
         3'd5: return "DIVU";
         3'd6: return "REM";
         default: return "REMU";
      endcase
   endfunction

   // plain-arithmetic reference following M-extension rules
   function automatic logic [15:0] ref_model(input logic [2:0] f,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
      longint sa;
      longint sb;
      longint ua;
      longint ub;
      longint r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      r  = 0;
      case (f)
         3'd0: r = ua * ub;
         3'd1: r = (sa * sb) >>> 16;
         3'd2: r = (sa * ub) >>> 16;
         3'd3: r = (ua * ub) >> 16;
         3'd4: if (b == 0) r = 'hFFFF; else r = sa / sb;
         3'd5: if (b == 0) r = 'hFFFF; else r = ua / ub;
         3'd6: if (b == 0) r = ua; else r = sa % sb;
         default: if (b == 0) r = ua; else r = ua % ub;
      endcase
      return r[15:0];
   endfunction

   // monitor
   logic prev_done = 1'b0;
   exp_t m_e;

   always @(negedge clk) begin
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (done) begin
            chk("done_back_to_back", 32'(prev_done), 0);
            if (sbq.size() == 0) begin
               chk("spurious_done", 32'(done), 0);
            end else begin
               m_e = sbq.pop_front();
               chk({m_e.name, "_data"}, 32'(wr_data), 32'(m_e.data));
               chk({m_e.name, "_latency"}, cyc, m_e.at);
               chk({m_e.name, "_wr_en"}, 32'(wr_en), 32'(m_e.we));
               if (m_e.we)
                  chk({m_e.name, "_wr_addr"}, 32'(wr_addr),
                      32'(m_e.addr));
            end
         end else begin
            chk("wr_en_outside_done", 32'(wr_en), 0);
            if (sbq.size() > 0 && cyc > sbq[0].at) begin
               chk({sbq[0].name, "_missing_done"}, cyc, sbq[0].at);
               void'(sbq.pop_front());
            end
         end
         prev_done = done;
      end
   end

   // mode: 0 quiet, 1 random junk while busy, 2 DIV starts at +3 and +17
   task automatic issue(input logic [2:0] f, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] rd,
                        input int mode);
      int   n;
      exp_t e;
      start   = 1'b1;
      op      = f;
      op_a    = a;
      op_b    = b;
      rd_addr = rd;
      @(posedge clk);
      #1;
      n      = cyc;
      e.data = ref_model(f, a, b);
      e.addr = rd;
      e.we   = (rd != 0);
      e.at   = n + 16;
      e.name = opname(f);
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
      chk("busy_after_start", 32'(busy), 1);
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         if (mode == 1) begin
            start   = 1'($urandom_range(0, 1));
            op      = 3'($urandom);
            op_a    = 16'($urandom);
            op_b    = 16'($urandom);
            rd_addr = 3'($urandom);
         end else if (mode == 2) begin
            start   = (cyc == n + 2) || (cyc == n + 16);
            op      = 3'd4;
            op_a    = 16'd100;
            op_b    = 16'd7;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk({opname(f), "_busy_release"}, cyc, n + 17);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_wr_en"}, 32'(wr_en), 0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
      chk({tag, "_wr_data"}, 32'(wr_data), 0);
   endtask

   initial begin
      int n;
      int seen;
      logic [15:0] ra;
      logic [15:0] rb;
      logic [2:0]  rf;

      // reset, with start held high to show reset wins
      rst   = 1'b1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      issue(3'd0, 16'h0007, 16'h0006, 3'd3, 0);
      issue(3'd0, 16'hFFFE, 16'h0003, 3'd1, 0);
      issue(3'd1, 16'hFFFE, 16'h0003, 3'd2, 0);
      issue(3'd3, 16'hFFFE, 16'h0003, 3'd4, 0);
      issue(3'd2, 16'hFFFF, 16'hFFFF, 3'd5, 0);
      issue(3'd4, 16'hFFF9, 16'h0002, 3'd6, 0);
      issue(3'd6, 16'hFFF9, 16'h0002, 3'd7, 0);
      issue(3'd5, 16'hFFF9, 16'h0002, 3'd1, 0);
      issue(3'd7, 16'hFFF9, 16'h0002, 3'd2, 0);
      issue(3'd4, 16'h1234, 16'h0000, 3'd3, 0);
      issue(3'd6, 16'h1234, 16'h0000, 3'd4, 0);
      issue(3'd5, 16'h0000, 16'h0000, 3'd5, 0);
      issue(3'd6, 16'h8765, 16'h0000, 3'd6, 0);
      issue(3'd4, 16'h8000, 16'hFFFF, 3'd6, 0);
      issue(3'd6, 16'h8000, 16'hFFFF, 3'd7, 0);

      // starts during CALC and DONE are ignored; next start is immediate
      issue(3'd0, 16'h0005, 16'h0005, 3'd2, 2);
      issue(3'd5, 16'h0064, 16'h0007, 3'd3, 0);

      // reset in the middle of a divide
      start   = 1'b1;
      op      = 3'd4;
      op_a    = 16'd1000;
      op_b    = 16'd7;
      rd_addr = 3'd5;
      @(posedge clk);
      #1;
      n = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < n + 7) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs("midop_reset");
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || wr_en || busy) seen++;
      end
      chk("activity_after_reset", seen, 0);

      // rd=0: done pulses without a write
      issue(3'd0, 16'h0002, 16'h0003, 3'd0, 0);

      // randomized traffic with junk starts while busy
      for (int k = 0; k < 150; k++) begin
         rf = 3'($urandom);
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 9))
            0: rb = 16'h0000;
            1: begin
               ra = 16'h8000;
               rb = 16'hFFFF;
            end
            2: rb = 16'(($urandom_range(0, 1) == 1) ? 16'h0001 : 16'hFFFF);
            default: ;
         endcase
         issue(rf, ra, rb, 3'($urandom), 1);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
